// File: rtl/psum_acc_sched_if.sv
// psum_acc_sched_if
//   Bundles the signals between the partial-sum accumulator/scheduler and
//   the blocks around it: the conv layer controller (cfg/start), the
//   operand source (src_stall), the 4-lane adder tree (iss_*/add_*), and
//   the post-processing stage (out_*).
//   slave  : the psum_acc_sched side.
//   master : the environment side (controller, adder tree, downstream).
//   Lane sums and output words are signed two's complement.
interface psum_acc_sched_if #(
   parameter int IN_W  = 22,
   parameter int ACC_W = 28
);
   logic                    cfg_start;
   logic [7:0]              cfg_num_tiles;
   logic [15:0]             cfg_num_pix;
   logic                    src_stall;
   logic                    iss_vld;
   logic                    iss_bias_en;
   logic [7:0]              iss_tile;
   logic [15:0]             iss_pix;
   logic                    add_vld;
   logic signed [IN_W-1:0]  add_sum0;
   logic signed [IN_W-1:0]  add_sum1;
   logic signed [IN_W-1:0]  add_sum2;
   logic signed [IN_W-1:0]  add_sum3;
   logic                    out_vld;
   logic                    out_rdy;
   logic signed [ACC_W-1:0] out_data0;
   logic signed [ACC_W-1:0] out_data1;
   logic signed [ACC_W-1:0] out_data2;
   logic signed [ACC_W-1:0] out_data3;
   logic                    busy;
   logic                    done;
   logic [1:0]              dbg_state;   // FSM state: 0 IDLE, 1 RUN, 2 DRAIN, 3 DONE

   modport slave (
      input  cfg_start, cfg_num_tiles, cfg_num_pix, src_stall,
      input  add_vld, add_sum0, add_sum1, add_sum2, add_sum3, out_rdy,
      output iss_vld, iss_bias_en, iss_tile, iss_pix,
      output out_vld, out_data0, out_data1, out_data2, out_data3,
      output busy, done, dbg_state
   );

   modport master (
      output cfg_start, cfg_num_tiles, cfg_num_pix, src_stall,
      output add_vld, add_sum0, add_sum1, add_sum2, add_sum3, out_rdy,
      input  iss_vld, iss_bias_en, iss_tile, iss_pix,
      input  out_vld, out_data0, out_data1, out_data2, out_data3,
      input  busy, done, dbg_state
   );
endinterface

// File: rtl/psum_acc_sched.sv
// psum_acc_sched
//   Walks the input-channel tiles of every output pixel, issuing one tile per
//   cycle to a 4-lane adder tree (bias added on tile 0 only), accumulates the
//   returned lane sums into four saturating signed accumulators, and queues
//   each finished pixel in a small output FIFO.
// Ports
//   clk, rstn : clock, asynchronous active-low reset
//   bus       : psum_acc_sched_if.slave
//     cfg_start/cfg_num_tiles/cfg_num_pix : job launch (sampled only in IDLE)
//     src_stall                           : operands not ready, hold issue
//     iss_vld/iss_bias_en/iss_tile/iss_pix: adder-tree issue
//     add_vld/add_sum0..3                 : adder-tree return
//     out_vld/out_rdy/out_data0..3        : finished pixels
//     busy/done/dbg_state                 : job status and FSM state
// Handshake: a pixel leaves the FIFO on every cycle with out_vld && out_rdy.
//   out_vld stays high and out_data stays unchanged until that happens.
module psum_acc_sched #(
   parameter int IN_W     = 22,
   parameter int ACC_W    = 28,
   parameter int TREE_LAT = 2,
   parameter int OFIFO_D  = 2
) (
   input logic             clk,
   input logic             rstn,
   psum_acc_sched_if.slave bus
);
   localparam int PW = (OFIFO_D > 1) ? $clog2(OFIFO_D) : 1;
   // Wide enough for FIFO occupancy plus pixels in flight (up to 2*OFIFO_D).
   localparam int CW = $clog2(OFIFO_D) + 2;
   localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t              state_q, state_d;
   logic [7:0]          ntiles_q, tile_q;
   logic [15:0]         npix_q, pix_q;
   logic [TREE_LAT-1:0] vld_sr_q, first_sr_q, last_sr_q;
   logic [ACC_W-1:0]    acc_q  [4];
   logic [ACC_W-1:0]    acc_nx [4];
   logic [ACC_W-1:0]    mem_q  [OFIFO_D][4];
   logic [PW-1:0]       wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]       cnt_q, infl_q;
   logic [IN_W-1:0]     sum_in [4];
   logic last_tile, last_pix, credit_ok, iss_fire;
   logic tag_vld, tag_first, tag_last, ret_fire, push, pop;

   assign sum_in[0] = bus.add_sum0;
   assign sum_in[1] = bus.add_sum1;
   assign sum_in[2] = bus.add_sum2;
   assign sum_in[3] = bus.add_sum3;

   assign last_tile = (tile_q == ntiles_q - 8'd1);
   assign last_pix  = (pix_q == npix_q - 16'd1);
   // Only the closing tile of a pixel needs a FIFO slot reserved; earlier
   // tiles never push, so they may issue even when the FIFO is full.
   assign credit_ok = !last_tile || ((cnt_q + infl_q) < CW'(OFIFO_D));
   assign iss_fire  = (state_q == S_RUN) && !bus.src_stall && credit_ok;

   // Tags leave the delay line in the same cycle the tree result arrives.
   assign tag_vld   = vld_sr_q[TREE_LAT-1];
   assign tag_first = first_sr_q[TREE_LAT-1];
   assign tag_last  = last_sr_q[TREE_LAT-1];
   assign ret_fire  = bus.add_vld && tag_vld;
   assign push      = ret_fire && tag_last;
   assign pop       = (cnt_q != '0) && bus.out_rdy;

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (bus.cfg_start) state_d = (bus.cfg_num_pix == 16'd0) ? S_DONE : S_RUN;
         S_RUN:   if (iss_fire && last_tile && last_pix) state_d = S_DRAIN;
         S_DRAIN: if (vld_sr_q == '0 && infl_q == '0 && cnt_q == '0) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Per-lane accumulate: the first tile reloads, later tiles add with
   // saturation one bit wider than the accumulator.
   always_comb begin
      logic [ACC_W-1:0] sx;
      logic [ACC_W:0]   wide;
      sx   = '0;
      wide = '0;
      for (int l = 0; l < 4; l++) begin
         sx   = {{(ACC_W-IN_W){sum_in[l][IN_W-1]}}, sum_in[l]};
         wide = {acc_q[l][ACC_W-1], acc_q[l]} + {sx[ACC_W-1], sx};
         if (tag_first)                       acc_nx[l] = sx;
         else if (wide[ACC_W] != wide[ACC_W-1]) acc_nx[l] = wide[ACC_W] ? ACC_MIN : ACC_MAX;
         else                                 acc_nx[l] = wide[ACC_W-1:0];
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= S_IDLE;
         ntiles_q   <= 8'd1;
         npix_q     <= 16'd0;
         tile_q     <= 8'd0;
         pix_q      <= 16'd0;
         vld_sr_q   <= '0;
         first_sr_q <= '0;
         last_sr_q  <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         cnt_q      <= '0;
         infl_q     <= '0;
         for (int l = 0; l < 4; l++) acc_q[l] <= '0;
         for (int d = 0; d < OFIFO_D; d++)
            for (int l = 0; l < 4; l++) mem_q[d][l] <= '0;
      end else begin
         state_q <= state_d;

         if (state_q == S_IDLE && bus.cfg_start) begin
            ntiles_q <= (bus.cfg_num_tiles == 8'd0) ? 8'd1 : bus.cfg_num_tiles;
            npix_q   <= bus.cfg_num_pix;
            tile_q   <= 8'd0;
            pix_q    <= 16'd0;
         end else if (iss_fire) begin
            if (last_tile) begin
               tile_q <= 8'd0;
               pix_q  <= last_pix ? 16'd0 : pix_q + 16'd1;
            end else begin
               tile_q <= tile_q + 8'd1;
            end
         end

         vld_sr_q[0]   <= iss_fire;
         first_sr_q[0] <= iss_fire && (tile_q == 8'd0);
         last_sr_q[0]  <= iss_fire && last_tile;
         for (int i = 1; i < TREE_LAT; i++) begin
            vld_sr_q[i]   <= vld_sr_q[i-1];
            first_sr_q[i] <= first_sr_q[i-1];
            last_sr_q[i]  <= last_sr_q[i-1];
         end

         if (ret_fire) begin
            for (int l = 0; l < 4; l++) acc_q[l] <= acc_nx[l];
         end

         if (push) begin
            for (int l = 0; l < 4; l++) mem_q[wr_ptr_q][l] <= acc_nx[l];
            wr_ptr_q <= wr_ptr_q + PW'(1);
         end
         if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
         cnt_q <= cnt_q + CW'(push) - CW'(pop);

         // A pixel stops being "in flight" when its closing tag leaves the
         // delay line, which is also when its FIFO push happens.
         infl_q <= infl_q + CW'(iss_fire && last_tile) - CW'(tag_vld && tag_last);
      end
   end

   assign bus.iss_vld     = iss_fire;
   assign bus.iss_bias_en = iss_fire && (tile_q == 8'd0);
   assign bus.iss_tile    = tile_q;
   assign bus.iss_pix     = pix_q;
   assign bus.out_vld     = (cnt_q != '0);
   assign bus.out_data0   = mem_q[rd_ptr_q][0];
   assign bus.out_data1   = mem_q[rd_ptr_q][1];
   assign bus.out_data2   = mem_q[rd_ptr_q][2];
   assign bus.out_data3   = mem_q[rd_ptr_q][3];
   assign bus.busy        = (state_q == S_RUN) || (state_q == S_DRAIN);
   assign bus.done        = (state_q == S_DONE);
   assign bus.dbg_state   = state_q;
endmodule

// File: tb/tb_psum_acc_sched.sv
module tb_psum_acc_sched;
   localparam int IN_W     = 22;
   localparam int ACC_W    = 28;
   localparam int TREE_LAT = 2;
   localparam int OFIFO_D  = 2;
   localparam int W        = 4 * ACC_W;
   localparam longint ACC_HI = (longint'(1) << (ACC_W-1)) - 1;
   localparam longint ACC_LO = -(longint'(1) << (ACC_W-1));
   localparam int IN_HI = (1 << (IN_W-1)) - 1;

   logic clk;
   logic rstn;
   psum_acc_sched_if #(.IN_W(IN_W), .ACC_W(ACC_W)) bus ();

   psum_acc_sched #(
      .IN_W(IN_W), .ACC_W(ACC_W), .TREE_LAT(TREE_LAT), .OFIFO_D(OFIFO_D)
   ) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   // ---------------- clock / reset / cycle counter ----------------
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int cyc = 0;
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // ---------------- reference model state ----------------
   int     m_ntiles, m_npix, m_tile, m_pix;
   longint m_acc [4];
   int     lane_val [4];
   int     sum_mode;        // 0 fixed lane_val, 1 full-range random, 3 rise-then-fall
   bit     spurious_en;
   logic [W-1:0]        exp_q [$];
   int                  due_q [$];
   logic [4*IN_W-1:0]   ret_q [$];
   logic [W-1:0]        last_got;
   int n_checks = 0;
   int n_fail   = 0;
   int n_issued, n_popped, n_done, first_iss_cyc, first_out_cyc;

   function automatic longint clamp(input longint v);
      if (v > ACC_HI) return ACC_HI;
      if (v < ACC_LO) return ACC_LO;
      return v;
   endfunction

   function automatic int gen_sum(input int lane, input int tile);
      if (sum_mode == 0) return lane_val[lane];
      if (sum_mode == 3) begin
         if (tile < 100) return int'($urandom_range(1 << 20, IN_HI));
         return -int'($urandom_range(1 << 20, 1 << 21));
      end
      return int'($urandom_range(0, (1 << IN_W) - 1)) - (1 << (IN_W-1));
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- adder-tree model: returns each issue TREE_LAT later ----------------
   initial begin
      logic [4*IN_W-1:0] pk;
      bus.add_vld = 1'b0;
      bus.add_sum0 = '0; bus.add_sum1 = '0; bus.add_sum2 = '0; bus.add_sum3 = '0;
      forever begin
         tick();
         if (due_q.size() > 0 && due_q[0] == cyc) begin
            pk = ret_q.pop_front();
            void'(due_q.pop_front());
            bus.add_vld  = 1'b1;
            bus.add_sum0 = pk[0*IN_W +: IN_W];
            bus.add_sum1 = pk[1*IN_W +: IN_W];
            bus.add_sum2 = pk[2*IN_W +: IN_W];
            bus.add_sum3 = pk[3*IN_W +: IN_W];
         end else begin
            // Untagged add_vld must be ignored; garbage sums must not matter.
            bus.add_vld  = spurious_en && ($urandom_range(0, 3) == 0);
            bus.add_sum0 = IN_W'($urandom);
            bus.add_sum1 = IN_W'($urandom);
            bus.add_sum2 = IN_W'($urandom);
            bus.add_sum3 = IN_W'($urandom);
         end
      end
   end

   // ---------------- monitor + scoreboard (samples at negedge) ----------------
   initial begin
      logic [W-1:0]      got, e, prev_data;
      logic [4*IN_W-1:0] pk;
      bit                hold_prev;
      int                s;
      longint            a;
      hold_prev = 0;
      prev_data = '0;
      forever begin
         @(negedge clk);
         if (!rstn) begin
            hold_prev = 0;
         end else begin
            if (bus.src_stall) begin
               n_checks++;
               if (bus.iss_vld !== 1'b0) begin
                  n_fail++;
                  $display("FAIL iss_while_stall: iss_vld=%0b required 0 (cyc %0d)", bus.iss_vld, cyc);
               end
            end
            if (bus.iss_vld === 1'b1) begin
               n_checks += 3;
               if (bus.iss_tile !== 8'(m_tile)) begin
                  n_fail++;
                  $display("FAIL iss_tile: got %0d required %0d", bus.iss_tile, m_tile);
               end
               if (bus.iss_pix !== 16'(m_pix)) begin
                  n_fail++;
                  $display("FAIL iss_pix: got %0d required %0d", bus.iss_pix, m_pix);
               end
               if (bus.iss_bias_en !== (m_tile == 0)) begin
                  n_fail++;
                  $display("FAIL iss_bias_en: got %0b required %0b at tile %0d", bus.iss_bias_en, m_tile == 0, m_tile);
               end
               if (m_pix >= m_npix) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL extra_issue: pixel %0d issued, job has %0d", m_pix, m_npix);
               end
               if (first_iss_cyc < 0) first_iss_cyc = cyc;
               n_issued++;
               e = '0;
               for (int l = 0; l < 4; l++) begin
                  s = gen_sum(l, m_tile);
                  pk[l*IN_W +: IN_W] = s[IN_W-1:0];
                  m_acc[l] = (m_tile == 0) ? longint'(s) : clamp(m_acc[l] + longint'(s));
                  a = m_acc[l];
                  e[l*ACC_W +: ACC_W] = a[ACC_W-1:0];
               end
               due_q.push_back(cyc + TREE_LAT);
               ret_q.push_back(pk);
               if (m_tile == m_ntiles - 1) begin
                  exp_q.push_back(e);
                  m_tile = 0;
                  m_pix++;
               end else begin
                  m_tile++;
               end
            end
            got = {bus.out_data3, bus.out_data2, bus.out_data1, bus.out_data0};
            if (hold_prev) begin
               n_checks++;
               if (bus.out_vld !== 1'b1 || got !== prev_data) begin
                  n_fail++;
                  $display("FAIL out_hold: vld=%0b data=%h required vld=1 data=%h", bus.out_vld, got, prev_data);
               end
            end
            if (bus.out_vld === 1'b1 && first_out_cyc < 0) first_out_cyc = cyc;
            if (bus.out_vld === 1'b1 && bus.out_rdy === 1'b1) begin
               n_checks++;
               n_popped++;
               last_got = got;
               if (exp_q.size() == 0) begin
                  n_fail++;
                  $display("FAIL out_unexpected: got %h with no pixel expected", got);
               end else begin
                  e = exp_q.pop_front();
                  if (got !== e) begin
                     n_fail++;
                     $display("FAIL out_data: got %h required %h", got, e);
                  end
               end
            end
            hold_prev = (bus.out_vld === 1'b1) && (bus.out_rdy === 1'b0);
            prev_data = got;
            if (bus.done === 1'b1) n_done++;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic start_job(input int tiles, input int pix);
      m_ntiles = (tiles == 0) ? 1 : tiles;
      m_npix = pix;
      m_tile = 0;
      m_pix = 0;
      n_issued = 0;
      n_popped = 0;
      n_done = 0;
      first_iss_cyc = -1;
      first_out_cyc = -1;
      bus.cfg_num_tiles = 8'(tiles);
      bus.cfg_num_pix = 16'(pix);
      bus.cfg_start = 1'b1;
      tick();
      bus.cfg_start = 1'b0;
   endtask

   // stall_mode: 0 none, 1 toggle, 2 random; rdy_mode: 0 always, 1 random
   task automatic wait_done(input int budget, input int stall_mode, input int rdy_mode, input string name);
      int i;
      i = 0;
      while (n_done == 0 && i < budget) begin
         case (stall_mode)
            1:       bus.src_stall = ~bus.src_stall;
            2:       bus.src_stall = ($urandom_range(0, 3) == 0);
            default: bus.src_stall = 1'b0;
         endcase
         bus.out_rdy = (rdy_mode == 1) ? ($urandom_range(0, 2) != 0) : 1'b1;
         tick();
         i++;
      end
      bus.src_stall = 1'b0;
      bus.out_rdy = 1'b1;
      n_checks++;
      if (n_done == 0) begin
         n_fail++;
         $display("FAIL %s_timeout: done=0 after %0d cycles, required a done pulse", name, budget);
      end
   endtask

   task automatic end_job(input int pix, input string name);
      tick(); tick(); tick();
      n_checks += 5;
      if (n_done != 1) begin
         n_fail++;
         $display("FAIL %s_done_count: got %0d pulses required 1", name, n_done);
      end
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL %s_leftover: %0d expected pixels never popped, required 0", name, exp_q.size());
      end
      if (n_popped != pix) begin
         n_fail++;
         $display("FAIL %s_popped: got %0d pixels required %0d", name, n_popped, pix);
      end
      if (m_pix != pix) begin
         n_fail++;
         $display("FAIL %s_issued_pix: got %0d pixels issued required %0d", name, m_pix, pix);
      end
      if (bus.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL %s_busy_after: got %0b required 0", name, bus.busy);
      end
   endtask

   task automatic check_idle_outputs(input string name);
      n_checks += 6;
      if (bus.iss_vld !== 1'b0 || bus.iss_bias_en !== 1'b0) begin
         n_fail++;
         $display("FAIL %s_iss: vld=%0b bias=%0b required 0 0", name, bus.iss_vld, bus.iss_bias_en);
      end
      if (bus.iss_tile !== 8'd0 || bus.iss_pix !== 16'd0) begin
         n_fail++;
         $display("FAIL %s_counters: tile=%0d pix=%0d required 0 0", name, bus.iss_tile, bus.iss_pix);
      end
      if (bus.out_vld !== 1'b0) begin
         n_fail++;
         $display("FAIL %s_out_vld: got %0b required 0", name, bus.out_vld);
      end
      if ({bus.out_data3, bus.out_data2, bus.out_data1, bus.out_data0} !== {W{1'b0}}) begin
         n_fail++;
         $display("FAIL %s_out_data: got %h required 0", name, {bus.out_data3, bus.out_data2, bus.out_data1, bus.out_data0});
      end
      if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
         n_fail++;
         $display("FAIL %s_status: busy=%0b done=%0b required 0 0", name, bus.busy, bus.done);
      end
      if (bus.dbg_state !== 2'd0) begin
         n_fail++;
         $display("FAIL %s_state: got %0d required 0 (IDLE)", name, bus.dbg_state);
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rstn = 1'b0;
      tick(); tick();
      check_idle_outputs("reset_low");
      rstn = 1'b1;
      tick(); tick();
      check_idle_outputs("reset_release");
   endtask

   task automatic test_single_tile();
      sum_mode = 0;
      lane_val[0] = 1; lane_val[1] = 2; lane_val[2] = 3; lane_val[3] = 4;
      start_job(1, 3);
      wait_done(100, 0, 0, "single_tile");
      n_checks++;
      if (first_out_cyc - first_iss_cyc != TREE_LAT + 1) begin
         n_fail++;
         $display("FAIL single_tile_latency: got %0d cycles required %0d", first_out_cyc - first_iss_cyc, TREE_LAT + 1);
      end
      end_job(3, "single_tile");
   endtask

   task automatic test_multi_tile();
      sum_mode = 0;
      for (int l = 0; l < 4; l++) lane_val[l] = 100;
      start_job(4, 2);
      tick();
      // A second start while busy must not disturb the running job.
      bus.cfg_num_tiles = 8'd1;
      bus.cfg_num_pix = 16'd1;
      bus.cfg_start = 1'b1;
      tick();
      bus.cfg_start = 1'b0;
      wait_done(100, 0, 0, "multi_tile");
      end_job(2, "multi_tile");
      n_checks++;
      if (last_got !== {28'd400, 28'd400, 28'd400, 28'd400}) begin
         n_fail++;
         $display("FAIL multi_tile_value: got %h required 400 per lane", last_got);
      end
   endtask

   task automatic test_backpressure();
      sum_mode = 1;
      bus.out_rdy = 1'b0;
      start_job(3, 4);
      for (int i = 0; i < 40; i++) tick();
      n_checks += 4;
      if (n_issued != OFIFO_D * 3 + 2) begin
         n_fail++;
         $display("FAIL bp_issued: got %0d issues required %0d", n_issued, OFIFO_D * 3 + 2);
      end
      if (bus.iss_tile !== 8'd2 || bus.iss_pix !== 16'(OFIFO_D)) begin
         n_fail++;
         $display("FAIL bp_hold_pos: tile=%0d pix=%0d required 2 %0d", bus.iss_tile, bus.iss_pix, OFIFO_D);
      end
      if (bus.out_vld !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_out_vld: got %0b required 1", bus.out_vld);
      end
      if (bus.busy !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_busy: got %0b required 1", bus.busy);
      end
      wait_done(200, 0, 0, "backpressure");
      end_job(4, "backpressure");
   endtask

   task automatic test_stall();
      sum_mode = 1;
      bus.src_stall = 1'b0;
      start_job(5, 3);
      wait_done(200, 1, 0, "stall");
      end_job(3, "stall");
   endtask

   task automatic test_saturation();
      logic [W-1:0] want;
      longint hi, lo;
      hi = ACC_HI;
      lo = ACC_LO;
      sum_mode = 0;
      lane_val[0] = IN_HI; lane_val[1] = IN_HI;
      lane_val[2] = -IN_HI - 1; lane_val[3] = -IN_HI - 1;
      start_job(255, 1);
      wait_done(600, 0, 0, "saturation");
      end_job(1, "saturation");
      want = {lo[ACC_W-1:0], lo[ACC_W-1:0], hi[ACC_W-1:0], hi[ACC_W-1:0]};
      n_checks++;
      if (last_got !== want) begin
         n_fail++;
         $display("FAIL sat_value: got %h required %h", last_got, want);
      end
   endtask

   task automatic test_sat_recover();
      sum_mode = 3;
      start_job(150, 2);
      wait_done(800, 0, 0, "sat_recover");
      end_job(2, "sat_recover");
   endtask

   task automatic test_zero_pix();
      start_job(5, 0);
      n_checks++;
      if (bus.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL zero_pix_busy: got %0b required 0", bus.busy);
      end
      wait_done(10, 0, 0, "zero_pix");
      end_job(0, "zero_pix");
      n_checks++;
      if (n_issued != 0) begin
         n_fail++;
         $display("FAIL zero_pix_issued: got %0d issues required 0", n_issued);
      end
   endtask

   task automatic test_random();
      int tiles, pix;
      sum_mode = 1;
      spurious_en = 1'b1;
      for (int j = 0; j < 6; j++) begin
         tiles = (j == 0) ? 0 : int'($urandom_range(1, 12));
         pix = int'($urandom_range(1, 6));
         start_job(tiles, pix);
         wait_done((tiles + 1) * pix * 8 + 100, 2, 1, "random");
         end_job(pix, "random");
      end
      spurious_en = 1'b0;
   endtask

   task automatic test_reset_mid_run();
      int i;
      sum_mode = 1;
      bus.out_rdy = 1'b0;
      start_job(3, 4);
      i = 0;
      while (bus.out_vld !== 1'b1 && i < 50) begin
         tick();
         i++;
      end
      n_checks++;
      if (bus.out_vld !== 1'b1) begin
         n_fail++;
         $display("FAIL midrst_fill: out_vld=%0b required 1 before reset", bus.out_vld);
      end
      #1;
      rstn = 1'b0;
      due_q.delete();
      ret_q.delete();
      exp_q.delete();
      #1;
      check_idle_outputs("midrst");
      tick(); tick();
      rstn = 1'b1;
      bus.out_rdy = 1'b1;
      tick();
      start_job(2, 3);
      wait_done(100, 0, 0, "after_rst");
      end_job(3, "after_rst");
   endtask

   initial begin
      bus.cfg_start = 1'b0;
      bus.cfg_num_tiles = 8'd0;
      bus.cfg_num_pix = 16'd0;
      bus.src_stall = 1'b0;
      bus.out_rdy = 1'b1;
      spurious_en = 1'b0;
      sum_mode = 0;
      m_ntiles = 1; m_npix = 0; m_tile = 0; m_pix = 0;
      n_issued = 0; n_popped = 0; n_done = 0;
      first_iss_cyc = -1; first_out_cyc = -1;
      for (int l = 0; l < 4; l++) begin
         m_acc[l] = 0;
         lane_val[l] = 0;
      end
      last_got = '0;
      rstn = 1'b0;
      test_reset();
      test_single_tile();
      test_multi_tile();
      test_backpressure();
      test_stall();
      test_saturation();
      test_sat_recover();
      test_zero_pix();
      test_random();
      test_reset_mid_run();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
